// File: rtl/branch_pht_lookup.sv
// Gshare pattern history table: 2-bit counters indexed by PC xor global history,
// with a power-up sweep, one-cycle prediction reads, write-first update bypass and GHR tracking.
module branch_pht_lookup #(
    parameter int         INDEX_BITS   = 10,
    parameter int         HIST_BITS    = 10,
    parameter logic [1:0] INIT_COUNTER = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_valid,
    input  logic [15:0]           lookup_pc,
    output logic                  ready,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [1:0]            pred_counter,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic [1:0]            upd_counter,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    output logic [HIST_BITS-1:0]  ghr
);

    localparam int TABLE_DEPTH = 2 ** INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_ENTRY = INDEX_BITS'(TABLE_DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [INDEX_BITS-1:0] sweep_ptr;
    logic [1:0]            pht [0:TABLE_DEPTH-1];

    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] lookup_idx;
    logic                  lookup_accept;
    logic                  upd_accept;
    logic                  resolve_accept;
    logic [1:0]            read_counter;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [1:0]            wr_data;
    logic                  unused_pc_bits;

    assign ready          = (state == ST_RUN);
    assign ghr_ext        = INDEX_BITS'(ghr);
    assign lookup_idx     = lookup_pc[INDEX_BITS:1] ^ ghr_ext;
    assign lookup_accept  = lookup_valid && ready;
    assign upd_accept     = upd_valid && ready;
    assign resolve_accept = resolve_valid && ready;
    assign unused_pc_bits = ^{lookup_pc[15:INDEX_BITS+1], lookup_pc[0]};

    // Write-first: an update landing on the looked-up entry this cycle wins over the stored value.
    assign read_counter = (upd_accept && (upd_index == lookup_idx)) ? upd_counter : pht[lookup_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                sweep_ptr <= sweep_ptr + INDEX_BITS'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_idx     = upd_index;
        wr_data    = upd_counter;
        unique case (state)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_idx  = sweep_ptr;
                wr_data = INIT_COUNTER;
                if (sweep_ptr == LAST_ENTRY) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_en = upd_accept;
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Table storage has no reset; the sweep is what gives it a defined value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pht[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid   <= 1'b0;
            pred_taken   <= 1'b0;
            pred_counter <= 2'b00;
            pred_index   <= '0;
        end else begin
            pred_valid <= lookup_accept;
            if (lookup_accept) begin
                pred_counter <= read_counter;
                pred_taken   <= read_counter[1];
                pred_index   <= lookup_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (resolve_accept) begin
            ghr <= {ghr[HIST_BITS-2:0], resolve_taken};
        end
    end

endmodule

// File: tb/tb_branch_pht_lookup.sv
// Directed self-checking bench for branch_pht_lookup: sweep timing, lookups, bypass, GHR and reset restart.
module tb_branch_pht_lookup;

    logic        clk;
    logic        rst_n;
    logic        lookup_valid;
    logic [15:0] lookup_pc;
    logic        ready;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_counter;
    logic [9:0]  pred_index;
    logic        upd_valid;
    logic [9:0]  upd_index;
    logic [1:0]  upd_counter;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [9:0]  ghr;

    int checks = 0;
    int passed = 0;
    int wait_cycles;
    logic pv_seen;

    branch_pht_lookup #(
        .INDEX_BITS  (10),
        .HIST_BITS   (10),
        .INIT_COUNTER(2'b01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .ready        (ready),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .pred_counter (pred_counter),
        .pred_index   (pred_index),
        .upd_valid    (upd_valid),
        .upd_index    (upd_index),
        .upd_counter  (upd_counter),
        .resolve_valid(resolve_valid),
        .resolve_taken(resolve_taken),
        .ghr          (ghr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic lv, input logic [15:0] pc,
                                 input logic uv, input logic [9:0] uidx, input logic [1:0] uctr,
                                 input logic rv, input logic rt);
        lookup_valid  = lv;
        lookup_pc     = pc;
        upd_valid     = uv;
        upd_index     = uidx;
        upd_counter   = uctr;
        resolve_valid = rv;
        resolve_taken = rt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Counts edges until ready rises, bounded so a stuck sweep still reaches the summary.
    task automatic waitReady();
        wait_cycles = 0;
        pv_seen     = 1'b0;
        while (!ready && wait_cycles < 2000) begin
            if (pred_valid) pv_seen = 1'b1;
            tick();
            wait_cycles++;
        end
        applyStimulus(0, 16'h0, 0, 10'h0, 2'b00, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 16'h0, 0, 10'h0, 2'b00, 0, 0);
        repeat (3) tick();
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_pred_valid", pred_valid, 0);
        checkOutput("reset_pred_taken", pred_taken, 0);
        checkOutput("reset_pred_counter", pred_counter, 2'b00);
        checkOutput("reset_pred_index", pred_index, 10'h000);
        checkOutput("reset_ghr", ghr, 10'h000);

        // T1: everything held active during the sweep must be ignored
        applyStimulus(1, 16'h0040, 1, 10'h020, 2'b11, 1, 1);
        rst_n = 1'b1;
        waitReady();
        checkOutput("t1_sweep_cycles", wait_cycles, 1024);
        checkOutput("t1_no_pred_in_init", pv_seen, 0);
        checkOutput("t1_pred_valid_at_ready", pred_valid, 0);
        checkOutput("t1_ghr_untouched", ghr, 10'h000);

        // T2: basic lookup, then hold behaviour
        applyStimulus(1, 16'h0040, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("t2_pred_valid", pred_valid, 1);
        checkOutput("t2_pred_counter", pred_counter, 2'b01);
        checkOutput("t2_pred_taken", pred_taken, 0);
        checkOutput("t2_pred_index", pred_index, 10'h020);
        applyStimulus(0, 16'h0, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("t2_pulse_drops", pred_valid, 0);
        checkOutput("t2_counter_holds", pred_counter, 2'b01);

        // T3: update then lookup
        applyStimulus(0, 16'h0, 1, 10'h020, 2'b11, 0, 0);
        tick();
        applyStimulus(1, 16'h0040, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("t3_pred_counter", pred_counter, 2'b11);
        checkOutput("t3_pred_taken", pred_taken, 1);

        // T4: same-cycle bypass, then update elsewhere must not disturb
        applyStimulus(1, 16'h0040, 1, 10'h020, 2'b10, 0, 0);
        tick();
        checkOutput("t4_bypass_counter", pred_counter, 2'b10);
        checkOutput("t4_bypass_taken", pred_taken, 1);
        applyStimulus(1, 16'h0040, 1, 10'h021, 2'b11, 0, 0);
        tick();
        checkOutput("t4_other_idx_counter", pred_counter, 2'b10);
        applyStimulus(1, 16'h0042, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("t4_other_idx_written", pred_counter, 2'b11);
        checkOutput("t4_other_idx_index", pred_index, 10'h021);

        // T5: history shift and old-ghr lookup with same-cycle resolve
        applyStimulus(0, 16'h0, 0, 10'h0, 2'b00, 1, 1);
        repeat (3) tick();
        checkOutput("t5_ghr_111", ghr, 10'h007);
        applyStimulus(1, 16'h0040, 0, 10'h0, 2'b00, 1, 0);
        tick();
        checkOutput("t5_index_old_ghr", pred_index, 10'h027);
        checkOutput("t5_counter", pred_counter, 2'b01);
        checkOutput("t5_ghr_shift_nt", ghr, 10'h00e);
        applyStimulus(1, 16'h0040, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("t5_index_new_ghr", pred_index, 10'h02e);

        // Last table entry: pc[10:1] = 0x3f1, xor ghr 0x00e -> 0x3ff
        applyStimulus(1, 16'h07e2, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("last_entry_index", pred_index, 10'h3ff);
        checkOutput("last_entry_counter", pred_counter, 2'b01);
        applyStimulus(0, 16'h0, 1, 10'h3ff, 2'b00, 0, 0);
        tick();
        applyStimulus(1, 16'h07e2, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("last_entry_updated", pred_counter, 2'b00);
        applyStimulus(0, 16'h0, 0, 10'h0, 2'b00, 0, 0);

        // T6: reset part-way through a sweep
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (500) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_ready", ready, 0);
        checkOutput("t6_reset_ghr", ghr, 10'h000);
        checkOutput("t6_reset_pred_index", pred_index, 10'h000);
        checkOutput("t6_reset_pred_counter", pred_counter, 2'b00);
        tick();
        applyStimulus(1, 16'h0040, 1, 10'h020, 2'b11, 1, 1);
        rst_n = 1'b1;
        waitReady();
        checkOutput("t6_sweep_cycles", wait_cycles, 1024);
        checkOutput("t6_no_pred_in_init", pv_seen, 0);
        checkOutput("t6_ghr_zero", ghr, 10'h000);
        applyStimulus(1, 16'h0040, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("t6_resweep_counter", pred_counter, 2'b01);
        checkOutput("t6_resweep_index", pred_index, 10'h020);
        applyStimulus(1, 16'h07fe, 0, 10'h0, 2'b00, 0, 0);
        tick();
        checkOutput("t6_resweep_last", pred_counter, 2'b01);
        applyStimulus(0, 16'h0, 0, 10'h0, 2'b00, 0, 0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
